// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction ROM arbiter.
package rom_arb_pkg;

  // Who owns the ROM word arriving in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam int ROM_AW_DEFAULT = 10;
  localparam int BURST_CNT_W    = 4;

  // Byte address to word address; the caller truncates to the ROM width,
  // which drops any address bits above the ROM without complaint.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/inst_rom_arbiter.sv
// Shares a single-port, 1-cycle-latency instruction ROM between the CPU fetch
// port and a debug read port. The CPU normally wins, but after MAX_CPU_BURST
// consecutive contended CPU grants the debug request is forced through.
//
// Handshake: a request is accepted in the cycle its *_gnt is high (grant is
// combinational from *_req). The matching *_rvalid/*_rdata appears exactly one
// cycle later. The debug master must hold dbg_req/dbg_addr until dbg_gnt; the
// CPU may change cpu_req every cycle and sees cpu_stall when not served.
module inst_rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_AW        = ROM_AW_DEFAULT,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [31:0]       cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic [31:0]       dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              rom_ce,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data
);

  localparam logic [BURST_CNT_W-1:0] MAX_B = BURST_CNT_W'(MAX_CPU_BURST);

  owner_e                 owner_q, owner_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [31:0]            cpu_hold_q, dbg_hold_q;

  logic              cpu_wins;
  logic [ROM_AW-1:0] cpu_waddr, dbg_waddr;

  assign cpu_waddr = ROM_AW'(byte_to_word(cpu_addr));
  assign dbg_waddr = ROM_AW'(byte_to_word(dbg_addr));

  // CPU wins unless debug is waiting and the CPU burst allowance is used up.
  assign cpu_wins = cpu_req & (~dbg_req | (burst_cnt_q < MAX_B));

  // Grant, stall and ROM drive; all forced quiet during reset.
  always_comb begin
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    rom_addr  = '0;
    if (!rst) begin
      cpu_gnt   = cpu_wins;
      dbg_gnt   = dbg_req & ~cpu_wins;
      cpu_stall = cpu_req & ~cpu_wins;
      if (cpu_gnt) begin
        rom_addr = cpu_waddr;
      end else if (dbg_gnt) begin
        rom_addr = dbg_waddr;
      end
    end
  end

  assign rom_ce = cpu_gnt | dbg_gnt;

  // Next owner and burst count from this cycle's grant.
  always_comb begin
    owner_d     = OWN_NONE;
    burst_cnt_d = burst_cnt_q;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
    end
    if (cpu_gnt && dbg_req) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (dbg_gnt || !dbg_req) begin
      burst_cnt_d = '0;
    end
  end

  // Owner, burst counter and per-port hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      burst_cnt_q <= '0;
      cpu_hold_q  <= '0;
      dbg_hold_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      if (owner_q == OWN_CPU) begin
        cpu_hold_q <= rom_data;
      end
      if (owner_q == OWN_DBG) begin
        dbg_hold_q <= rom_data;
      end
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign dbg_rvalid = (owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? rom_data : cpu_hold_q;
  assign dbg_rdata  = dbg_rvalid ? rom_data : dbg_hold_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed vectors, a behavioural model checked
// every cycle, and literal expectations at the interesting points.
module tb_inst_rom_arbiter;

  localparam int AW        = 10;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic          dbg_req = 1'b0;
  logic [31:0]   dbg_addr = '0;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data = '0;

  inst_rom_arbiter #(.ROM_AW(AW), .MAX_CPU_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  // ROM contents: every word is distinct and easy to recognise.
  function automatic logic [31:0] rom_word(input int a);
    return 32'hC0DE_0000 | (a & 32'h3FF);
  endfunction

  // Synchronous ROM, one cycle of latency.
  always @(posedge clk) begin
    if (rom_ce) rom_data <= rom_word(int'(rom_addr));
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected responses: {who[1:0], word_addr[9:0]}, who 1=CPU 2=DBG.
  logic [11:0] exp_q[$];
  int          m_run   = 0;   // consecutive contended CPU grants
  logic [31:0] m_cpu_h = '0;
  logic [31:0] m_dbg_h = '0;

  // Model: grant rules, address mapping and response routing, every cycle.
  always @(negedge clk) begin
    bit          e_cg, e_dg, e_cv, e_dv;
    int          e_addr;
    logic [11:0] ent;
    logic [31:0] e_cd, e_dd;
    e_cg   = !rst && cpu_req && (!dbg_req || m_run < MAX_BURST);
    e_dg   = !rst && dbg_req && !e_cg;
    e_addr = e_cg ? int'((cpu_addr / 4) % (1 << AW)) :
             e_dg ? int'((dbg_addr / 4) % (1 << AW)) : 0;
    e_cv = 1'b0; e_dv = 1'b0;
    e_cd = m_cpu_h; e_dd = m_dbg_h;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      if (ent[11:10] == 2'd1) begin e_cv = 1'b1; e_cd = rom_word(int'(ent[9:0])); end
      if (ent[11:10] == 2'd2) begin e_dv = 1'b1; e_dd = rom_word(int'(ent[9:0])); end
    end
    check("cpu_gnt",    cpu_gnt,    e_cg);
    check("dbg_gnt",    dbg_gnt,    e_dg);
    check("cpu_stall",  cpu_stall,  !rst && cpu_req && !e_cg);
    check("rom_ce",     rom_ce,     e_cg || e_dg);
    check("rom_addr",   rom_addr,   e_addr);
    check("cpu_rvalid", cpu_rvalid, e_cv);
    check("dbg_rvalid", dbg_rvalid, e_dv);
    check("cpu_rdata",  cpu_rdata,  e_cd);
    check("dbg_rdata",  dbg_rdata,  e_dd);
    check("one_rvalid", cpu_rvalid & dbg_rvalid, 1'b0);
    // Advance model state to the next cycle.
    if (e_cg) exp_q.push_back({2'd1, 10'(e_addr)});
    if (e_dg) exp_q.push_back({2'd2, 10'(e_addr)});
    if (rst) begin
      m_run = 0; m_cpu_h = '0; m_dbg_h = '0;
    end else begin
      if (e_cv) m_cpu_h = e_cd;
      if (e_dv) m_dbg_h = e_dd;
      m_run = (e_cg && dbg_req) ? m_run + 1 : 0;
    end
  end

  // ---------------- driver ----------------
  // Apply one cycle of inputs just after the clock edge, return mid-cycle.
  task automatic cyc(input logic r, input logic cr, input logic [31:0] ca,
                     input logic dr, input logic [31:0] da);
    @(posedge clk); #1;
    rst = r; cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc(1, 0, 0, 0, 0);
    // Reset state.
    cyc(0, 0, 0, 0, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);
    check("rst_cpu_rdata",  cpu_rdata,  0);
    check("rst_dbg_rdata",  dbg_rdata,  0);

    // CPU only, three sequential fetches.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'(4 * i), 0, 0);
      check("cpu_only_addr",  rom_addr,  i);
      check("cpu_only_stall", cpu_stall, 0);
      if (i > 0) check("cpu_only_data", cpu_rdata, 32'hC0DE_0000 + 32'(i - 1));
    end
    cyc(0, 0, 0, 0, 0);
    check("cpu_only_last_v", cpu_rvalid, 1);
    check("cpu_only_last_d", cpu_rdata,  32'hC0DE_0002);
    cyc(0, 0, 0, 0, 0);
    check("cpu_hold_v", cpu_rvalid, 0);
    check("cpu_hold_d", cpu_rdata,  32'hC0DE_0002);

    // Debug only.
    cyc(0, 0, 0, 1, 32'h40C);
    check("dbg_only_gnt",  dbg_gnt,  1);
    check("dbg_only_addr", rom_addr, 10'h103);
    cyc(0, 0, 0, 0, 0);
    check("dbg_only_v", dbg_rvalid, 1);
    check("dbg_only_d", dbg_rdata,  32'hC0DE_0103);
    cyc(0, 0, 0, 0, 0);
    check("dbg_hold_v", dbg_rvalid, 0);
    check("dbg_hold_d", dbg_rdata,  32'hC0DE_0103);

    // Contention: CPU x4 then DBG, repeating.
    for (int k = 0; k < 10; k++) begin
      cyc(0, 1, 32'h100 + 32'(4 * k), 1, 32'h200);
      check("cont_dbg_gnt",   dbg_gnt,   (k % 5) == 4);
      check("cont_cpu_gnt",   cpu_gnt,   (k % 5) != 4);
      check("cont_cpu_stall", cpu_stall, (k % 5) == 4);
    end
    cyc(0, 0, 0, 0, 0);

    // Unaligned, high address bits ignored.
    cyc(0, 1, 32'hFFFF_F00F, 0, 0);
    check("unal_addr", rom_addr, 10'h003);
    cyc(0, 0, 0, 0, 0);
    check("unal_v", cpu_rvalid, 1);
    check("unal_d", cpu_rdata,  32'hC0DE_0003);

    // Reset mid-flight: grant before reset still returns, request during
    // reset is dropped and the hold register is cleared.
    cyc(0, 1, 32'h14, 0, 0);
    cyc(1, 1, 32'h18, 0, 0);
    check("rmf_gnt",   cpu_gnt,   0);
    check("rmf_ce",    rom_ce,    0);
    check("rmf_stall", cpu_stall, 0);
    check("rmf_prev",  cpu_rdata, 32'hC0DE_0005);
    cyc(0, 0, 0, 0, 0);
    check("rmf_v", cpu_rvalid, 0);
    check("rmf_d", cpu_rdata,  0);

    // Interleave: DBG then CPU on consecutive cycles.
    cyc(0, 0, 0, 1, 32'h8);
    check("il_dbg_gnt", dbg_gnt, 1);
    cyc(0, 1, 32'hC, 0, 0);
    check("il_dbg_v",  dbg_rvalid, 1);
    check("il_dbg_d",  dbg_rdata,  32'hC0DE_0002);
    check("il_cpu_v0", cpu_rvalid, 0);
    cyc(0, 0, 0, 0, 0);
    check("il_cpu_v", cpu_rvalid, 1);
    check("il_cpu_d", cpu_rdata,  32'hC0DE_0003);
    check("il_dbg_v0", dbg_rvalid, 0);

    // Mixed pattern with debug arriving mid-burst and CPU toggling.
    for (int k = 0; k < 16; k++) begin
      if (k % 3 == 2) cyc(0, 0, 0, 1, 32'h300 + 32'(k));
      else            cyc(0, 1, 32'h80 + 32'(8 * k), (k > 6), 32'h3F0);
    end
    repeat (3) cyc(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single-port synchronous instruction ROM (1-cycle read latency, word-addressed) between the CPU fetch port and a debug/monitor read port.
- Sits between the pipeline core, the debug reader and the ROM.
- Issues the ROM enable and address, and routes each returned word to the requester that owns it.
- Tells the CPU when its fetch was not served (stall), using bounded CPU priority so the debug port cannot starve.

Parameters:
ROM_AW, 10, ROM word-address width; ROM address = byte address bits [ROM_AW+1:2]
MAX_CPU_BURST, 4, consecutive contended CPU grants before debug is forced through; legal 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU fetch request, level, may change every cycle
cpu_addr  in  32  CPU byte address
cpu_gnt  out  1  CPU request accepted this cycle (combinational)
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU read data valid (cycle after grant)
cpu_rdata  out  32  CPU read data
dbg_req  in  1  debug read request, held until granted
dbg_addr  in  32  debug byte address
dbg_gnt  out  1  debug request accepted this cycle (combinational)
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  32  debug read data
rom_ce  out  1  ROM enable
rom_addr  out  ROM_AW  ROM word address
rom_data  in  32  ROM output, valid the cycle after rom_ce

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- In the cycle after rst is high: cpu_rvalid=0, dbg_rvalid=0, owner=NONE, burst_cnt=0, held data registers=0.
- cpu_gnt, dbg_gnt, rom_ce and cpu_stall are forced 0 while rst=1.

Grant (combinational, one grant per cycle):
- Only cpu_req: CPU granted.
- Only dbg_req: debug granted.
- Both, burst_cnt < MAX_CPU_BURST: CPU granted.
- Both, burst_cnt == MAX_CPU_BURST: debug granted.
- Neither: no grant.

ROM drive:
- rom_ce = cpu_gnt | dbg_gnt.
- rom_addr = winner address bits [ROM_AW+1:2].
- With no grant, rom_addr = 0.
- Byte-address bits [1:0] and bits above ROM_AW+1 are ignored (no error signalled).

burst_cnt (4 bits), registered:
- CPU granted while dbg_req=1: increment.
- Debug granted, or dbg_req=0: clear.
- Never exceeds MAX_CPU_BURST.

Owner register:
- Next value = CPU / DBG / NONE according to this cycle's grant.

Response, cycle N+1 after a grant in cycle N:
- owner==CPU: cpu_rvalid=1 and cpu_rdata=rom_data.
- owner==DBG: dbg_rvalid=1 and dbg_rdata=rom_data.
- Exactly one rvalid is high per granted cycle; both are never high together.

Data hold:
- Each port captures rom_data into its held register on its rvalid.
- While that port's rvalid=0, its rdata shows the held value.

Back-to-back:
- A new grant is allowed every cycle, giving full throughput.
- Responses keep grant order, 1-cycle latency.

Reset mid-operation:
- A grant issued in the cycle rst rises is dropped; no rvalid follows.

Debug handshake:
- The debug master keeps dbg_req/dbg_addr stable until dbg_gnt.
- The arbiter has no request buffering.

Decomposition:
- Package rom_arb_pkg:
  - owner enum OWN_NONE/OWN_CPU/OWN_DBG (2 bits)
  - ROM_AW_DEFAULT=10
  - BURST_CNT_W=4
  - a function converting a byte address to a word address
- No sub-module; the grant logic, counter, owner register and hold registers are small enough to live in one module.

Test Plan:
- CPU only: cpu_req=1 for 3 cycles, addrs 0x0, 0x4, 0x8.
  -> rom_addr 0, 1, 2 in those cycles; cpu_rvalid=1 the following 3 cycles with ROM words 0..2; cpu_stall=0 throughout.
- Debug only: dbg_req=1, dbg_addr=0x40C.
  -> dbg_gnt=1 the same cycle, rom_addr=0x103; dbg_rvalid=1 next cycle with word 0x103; then dbg_rdata holds that word.
- Contention, MAX_CPU_BURST=4: cpu_req and dbg_req both held high.
  -> grants CPU, CPU, CPU, CPU, DBG, CPU×4, DBG…; cpu_stall=1 exactly in the DBG cycles; burst_cnt returns to 0 after each DBG grant.
- Unaligned and high address: cpu_addr=0xFFFF_F00F, ROM_AW=10.
  -> rom_addr=0x003; normal response, no error.
- Reset mid-flight: CPU grant in cycle N with rst=1 in cycle N.
  -> cpu_rvalid=0 in N+1; cpu_rdata=0; owner=NONE.
- Interleave: cycle N DBG grant at 0x8, cycle N+1 CPU grant at 0xC.
  -> N+1: dbg_rvalid=1 with word 2; N+2: cpu_rvalid=1 with word 3; never both rvalids in one cycle.
